// File: rtl/fp_mul_issue_ctrl.sv
// fp_mul_issue_ctrl
// -----------------
// Single-outstanding issue/collect controller that sits directly in front of
// a combinational floating_point_multiplier. One operand pair is accepted at a
// time, driven onto the multiplier inputs and held there. After MUL_LATENCY
// edges the product and exception flags are captured into an output register
// that is presented on its own valid/ready handshake. Sticky exception flags
// accumulate every captured flag set until sticky_clr.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake
//   in_a, in_b, in_rnd_mode       operand pair and rounding mode
//   mul_a, mul_b, mul_rnd_mode    registered drive to the multiplier
//   mul_product, mul_flags        multiplier result, flags {inv,ovf,unf}
//   out_valid/out_ready           result handshake
//   out_product, out_flags        captured result and flags
//   sticky_flags, sticky_clr      accumulated flags and their clear
//   busy                          high whenever the controller is not IDLE
//
// Optional feature (macro FP_MUL_ISSUE_STATS_EN): adds saturating CNT_WIDTH
// counters op_count, inv_count, ovf_count and unf_count, cleared by rst and
// by sticky_clr.

module fp_mul_issue_ctrl #(
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23,
  parameter int MUL_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     in_a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     in_b,
  input  logic [2:0]                        in_rnd_mode,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     mul_a,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     mul_b,
  output logic [2:0]                        mul_rnd_mode,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     mul_product,
  input  logic [2:0]                        mul_flags,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     out_product,
  output logic [2:0]                        out_flags,
  output logic [2:0]                        sticky_flags,
  input  logic                              sticky_clr,
  output logic                              busy
`ifdef FP_MUL_ISSUE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]              op_count,
  output logic [CNT_WIDTH-1:0]              inv_count,
  output logic [CNT_WIDTH-1:0]              ovf_count,
  output logic [CNT_WIDTH-1:0]              unf_count
`endif
);

  localparam int CW = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept, capture;

  // State and latency counter register. Reset drops any operation in flight,
  // so no out_valid can follow a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The capture edge is the WAIT edge where cnt is 1, which
  // lands exactly MUL_LATENCY edges after the accept edge. in_valid is only
  // looked at in IDLE, so requests during WAIT/HOLD are simply not accepted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          cnt_next   = CW'(MUL_LATENCY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // Operand registers feed a combinational multiplier, so they only move on
  // an accept and otherwise hold the last operation's inputs indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a        <= '0;
      mul_b        <= '0;
      mul_rnd_mode <= '0;
    end else if (accept) begin
      mul_a        <= in_a;
      mul_b        <= in_b;
      mul_rnd_mode <= in_rnd_mode;
    end
  end

  // Result capture and sticky flags. A clear coinciding with a capture keeps
  // the flags of the op being captured rather than discarding them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_product  <= '0;
      out_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      if (capture) begin
        out_product <= mul_product;
        out_flags   <= mul_flags;
      end
      if (capture && sticky_clr) sticky_flags <= mul_flags;
      else if (capture)          sticky_flags <= sticky_flags | mul_flags;
      else if (sticky_clr)       sticky_flags <= '0;
    end
  end

`ifdef FP_MUL_ISSUE_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Statistics counters. On a clear they restart from zero, but a capture on
  // the same edge still contributes its own count.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      inv_count <= '0;
      ovf_count <= '0;
      unf_count <= '0;
    end else if (capture && sticky_clr) begin
      op_count  <= CNT_WIDTH'(1);
      inv_count <= CNT_WIDTH'(mul_flags[2]);
      ovf_count <= CNT_WIDTH'(mul_flags[1]);
      unf_count <= CNT_WIDTH'(mul_flags[0]);
    end else if (capture) begin
      op_count <= sat_inc(op_count);
      if (mul_flags[2]) inv_count <= sat_inc(inv_count);
      if (mul_flags[1]) ovf_count <= sat_inc(ovf_count);
      if (mul_flags[0]) unf_count <= sat_inc(unf_count);
    end else if (sticky_clr) begin
      op_count  <= '0;
      inv_count <= '0;
      ovf_count <= '0;
      unf_count <= '0;
    end
  end
`endif

endmodule
